code_lock_checker: RTL and testbench

//   Consumer end of the random-digit stream: samples the free-running 0..9 digit generator into a

---
 rtl/code_lock_pkg.sv | 13 +
 rtl/lock_timer.sv | 23 ++
 rtl/code_lock_checker.sv | 131 +++++++++++++
 tb/tb_code_lock_checker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// Shared types for the code lock checker: digit type, digit range limit and FSM states.
package code_lock_pkg;
  typedef logic [3:0] digit_t;
  localparam digit_t DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE, CAPTURE, WAIT_ENTRY, CHECK, UNLOCK, LOCKOUT
  } state_t;

  function automatic logic digit_ok(input digit_t d);
    return d <= DIGIT_MAX;
  endfunction
endpackage

// File: rtl/lock_timer.sv
// Lockout duration counter: load to LOCK_CYCLES, count down while enabled,
// done flags the last lockout cycle.
module lock_timer #(
  parameter int LOCK_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int W = $clog2(LOCK_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST)                   cnt <= '0;
    else if (load)             cnt <= W'(LOCK_CYCLES);
    else if (en && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));
endmodule

// File: rtl/code_lock_checker.sv
// Captures a CODE_LEN-digit secret from the random digit stream and checks keypad entries.
// Optional CODE_LOCK_DEBUG_EN adds DBG_CODE exposing the secret (digit 0 in LSBs).
module code_lock_checker
  import code_lock_pkg::*;
#(
  parameter int CODE_LEN    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [3:0]                       RAND_D,
  input  logic                             ARM,
  input  logic                             KEY_VALID,
  input  logic [3:0]                       KEY_DIGIT,
  output logic                             CODE_READY,
  output logic                             UNLOCKED,
  output logic                             FAIL,
  output logic                             LOCKED_OUT,
  output logic [$clog2(MAX_TRIES+1)-1:0]   TRIES_LEFT
`ifdef CODE_LOCK_DEBUG_EN
  ,
  output logic [4*CODE_LEN-1:0]            DBG_CODE
`endif
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = $clog2(CODE_LEN);

  state_t                    state, nxt;
  digit_t [CODE_LEN-1:0]     secret, entry;
  logic   [IW-1:0]           cidx, eidx;
  logic   [CODE_LEN-1:0]     dig_eq;
  logic                      match, rand_ok, last_cap, last_key, tmr_done;
  logic                      code_ready_d, unlocked_d, fail_d, locked_d;
  logic   [TW-1:0]           tries_d;

  // An out-of-range entered digit can never match a stored digit.
  for (genvar g = 0; g < CODE_LEN; g++) begin : g_cmp
    assign dig_eq[g] = (entry[g] == secret[g]) && digit_ok(entry[g]);
  end

  assign match    = &dig_eq;
  assign rand_ok  = digit_ok(RAND_D);
  assign last_cap = rand_ok && (cidx == IW'(CODE_LEN - 1));
  assign last_key = KEY_VALID && (eidx == IW'(CODE_LEN - 1));

  lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .load (state == CHECK && nxt == LOCKOUT),
    .en   (state == LOCKOUT),
    .done (tmr_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      CODE_READY <= 1'b0;
      UNLOCKED   <= 1'b0;
      FAIL       <= 1'b0;
      LOCKED_OUT <= 1'b0;
      TRIES_LEFT <= TW'(MAX_TRIES);
    end else begin
      state      <= nxt;
      CODE_READY <= code_ready_d;
      UNLOCKED   <= unlocked_d;
      FAIL       <= fail_d;
      LOCKED_OUT <= locked_d;
      TRIES_LEFT <= tries_d;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:       if (ARM) nxt = CAPTURE;
      CAPTURE:    if (last_cap) nxt = WAIT_ENTRY;
      WAIT_ENTRY: if (ARM) nxt = CAPTURE;
                  else if (last_key) nxt = CHECK;
      CHECK:      if (match) nxt = UNLOCK;
                  else if (TRIES_LEFT <= TW'(1)) nxt = LOCKOUT;
                  else nxt = WAIT_ENTRY;
      UNLOCK:     if (ARM) nxt = CAPTURE;
      LOCKOUT:    if (tmr_done) nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  // Outputs are computed from the transition so they line up with the registered state;
  // CODE_READY lags the capture completion by one cycle.
  always_comb begin
    code_ready_d = (nxt inside {WAIT_ENTRY, CHECK, UNLOCK}) && (state != CAPTURE);
    unlocked_d   = (nxt == UNLOCK);
    fail_d       = (state == CHECK) && !match;
    locked_d     = (nxt == LOCKOUT);
    tries_d      = TRIES_LEFT;
    if (nxt == CAPTURE || (state == LOCKOUT && nxt == IDLE))
      tries_d = TW'(MAX_TRIES);
    else if (fail_d && TRIES_LEFT != '0)
      tries_d = TRIES_LEFT - TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      secret <= '0;
      entry  <= '0;
      cidx   <= '0;
      eidx   <= '0;
    end else begin
      if (state == CAPTURE && rand_ok) begin
        secret[cidx] <= RAND_D;
        cidx         <= cidx + IW'(1);
      end else if (state != CAPTURE) begin
        cidx <= '0;
      end
      if (state == LOCKOUT && tmr_done)
        secret <= '0;
      // ARM during entry discards whatever partial code was typed.
      if (state == WAIT_ENTRY && !ARM && KEY_VALID) begin
        entry[eidx] <= KEY_DIGIT;
        eidx        <= eidx + IW'(1);
      end else if (state != WAIT_ENTRY || ARM) begin
        eidx <= '0;
      end
    end
  end

`ifdef CODE_LOCK_DEBUG_EN
  assign DBG_CODE = secret;
`endif
endmodule

// File: tb/tb_code_lock_checker.sv
// Directed bench for code_lock_checker with CODE_LEN=4, MAX_TRIES=3, LOCK_CYCLES=8.
module tb_code_lock_checker;
  logic       clk = 1'b0;
  logic       rst, arm, key_valid;
  logic [3:0] rand_d, key_digit;
  logic       code_ready, unlocked, fail, locked_out;
  logic [1:0] tries_left;
`ifdef CODE_LOCK_DEBUG_EN
  logic [15:0] dbg_code;
`endif

  int checks = 0;
  int errors = 0;

  code_lock_checker #(.CODE_LEN(4), .MAX_TRIES(3), .LOCK_CYCLES(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .RAND_D     (rand_d),
    .ARM        (arm),
    .KEY_VALID  (key_valid),
    .KEY_DIGIT  (key_digit),
    .CODE_READY (code_ready),
    .UNLOCKED   (unlocked),
    .FAIL       (fail),
    .LOCKED_OUT (locked_out),
    .TRIES_LEFT (tries_left)
`ifdef CODE_LOCK_DEBUG_EN
    ,
    .DBG_CODE   (dbg_code)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the four digits of code (digit 0 in the low nibble) from the random stream,
  // then one more cycle so CODE_READY has risen.
  task automatic feed(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      rand_d = code[4*i +: 4];
      tick();
    end
    rand_d = 4'hF;
    tick();
  endtask

  task automatic capture(input logic [15:0] code);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    feed(code);
  endtask

  // Leaves the DUT in CHECK; the result shows after the next tick.
  task automatic enter(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_digit = code[4*i +: 4];
      tick();
    end
    key_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"},  code_ready, 0);
    chk({tag, "_unl"},    unlocked,   0);
    chk({tag, "_fail"},   fail,       0);
    chk({tag, "_locked"}, locked_out, 0);
    chk({tag, "_tries"},  tries_left, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; key_valid = 1'b0; rand_d = 4'd0; key_digit = 4'd0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("rst");

    // 1: capture with an out-of-range digit skipped
    arm = 1'b1; tick(); arm = 1'b0;
    rand_d = 4'd3;  tick();
    rand_d = 4'd12; tick();
    rand_d = 4'd7;  tick();
    rand_d = 4'd1;  tick();
    rand_d = 4'd9;  tick();
    chk("cr_early", code_ready, 0);
    rand_d = 4'd5;  tick();
    chk("cr_rise", code_ready, 1);

    // 2: correct entry
    enter(16'h9173);
    chk("unl_early", unlocked, 0);
    tick();
    chk("unl_set", unlocked, 1);
    chk("unl_nofail", fail, 0);
    chk("unl_tries", tries_left, 3);
    tick();
    chk("unl_hold", unlocked, 1);
    chk("unl_ready", code_ready, 1);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm_unl", unlocked, 0);
    chk("rearm_ready", code_ready, 0);
    feed(16'h9173);
    chk("recap_ready", code_ready, 1);

    // 3 + 4: three wrong entries, lockout ignores ARM and keys
    for (int n = 0; n < 3; n++) begin
      enter(16'h8173);
      tick();
      chk("wrong_fail", fail, 1);
      chk("wrong_tries", tries_left, 2 - n);
      if (n < 2) begin
        tick();
        chk("fail_pulse", fail, 0);
      end
    end
    chk("lock_rise", locked_out, 1);
    chk("lock_ready", code_ready, 0);
    for (int c = 2; c <= 8; c++) begin
      arm = 1'b1; key_valid = 1'b1; key_digit = 4'd3;
      tick();
      chk("lock_hold", locked_out, 1);
    end
    chk("lock_nofail", fail, 0);
    arm = 1'b0; key_valid = 1'b0;
    tick();
    chk("lock_end", locked_out, 0);
    chk("lock_tries", tries_left, 3);
    chk("lock_idle", code_ready, 0);

    // 5: ARM together with a key strobe discards the partial entry and reloads tries
    capture(16'h9173);
    enter(16'h8173);
    tick();
    chk("t5_tries", tries_left, 2);
    key_valid = 1'b1; key_digit = 4'd3; tick();
    key_digit = 4'd7; tick();
    arm = 1'b1; key_digit = 4'd1; tick();
    arm = 1'b0; key_valid = 1'b0;
    chk("t5_ready", code_ready, 0);
    chk("t5_reload", tries_left, 3);
    feed(16'h8642);
    chk("t5_recap", code_ready, 1);
    enter(16'h8642);
    tick();
    chk("t5_unl", unlocked, 1);
    chk("t5_nofail", fail, 0);

    // 6: reset mid-capture, out-of-range key digit, reset mid-lockout
    arm = 1'b1; tick(); arm = 1'b0;
    rand_d = 4'd5; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst_cap");
    feed(16'h1111);
    chk("rst_cap_idle", code_ready, 0);

    capture(16'h3210);
    enter(16'hA210);
    tick();
    chk("bad_digit_fail", fail, 1);
    chk("bad_digit_tries", tries_left, 2);
    tick();

    capture(16'h4321);
    for (int n = 0; n < 3; n++) begin
      enter(16'h0000);
      tick();
      tick();
    end
    chk("rst_lock_pre", locked_out, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst_lock");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
